conv_encoder_k3: RTL and testbench
==================================

CONV_ENCODER_K3 -- requirements
Module: conv_encoder_k3

Interface
REQ-001 Parameter G0, default 3'b111, generator polynomial for symbol bit 1 (taps {u,d1,d2}).
REQ-002 Parameter G1, default 3'b101, generator polynomial for symbol bit 0 (taps {u,d1,d2}).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  source holds in_bit/in_last valid.
REQ-006 in_ready  output  1  encoder accepts a data bit this cycle.
REQ-007 in_bit  input  1  information bit u.
REQ-008 in_last  input  1  marks the final data bit of a frame.
REQ-009 out_valid  output  1  out_sym/out_last valid.
REQ-010 out_ready  input  1  sink accepts the symbol this cycle.
REQ-011 out_sym  output  2  coded symbol {g0,g1}.
REQ-012 out_last  output  1  marks the final symbol of a frame.
REQ-013 enc_state  output  2  trellis state {d1,d2}, numbered as decoder states 00/01/10/11.
REQ-014 busy  output  1  high from first accepted bit of a frame until its last symbol is consumed.

Function
REQ-015 Rate 1/2, K=3 encoder; d1 = previous input bit, d2 = bit before it.
REQ-016 For input u: g0 = XOR of {u,d1,d2} masked by G0, g1 = same masked by G1; next state = {u,d1}.
REQ-017 Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-018 Single output register; slot free when !out_valid or out_ready high this cycle.
REQ-019 in_ready = (FSM in DATA) && slot free; combinational from out_ready, no dependence on in_valid.
REQ-020 Latency: symbol appears on out_sym with out_valid the cycle after input transfer.
REQ-021 Throughput: one symbol per cycle with in_valid and out_ready continuously high.
REQ-022 While out_valid && !out_ready, out_sym, out_last, enc_state held stable.
REQ-023 FSM states DATA, TAIL1, TAIL2; reset state DATA.
REQ-024 DATA -> TAIL1 on transfer with in_last=1 (tail enabled, REQ-031); otherwise stay DATA.
REQ-025 TAIL1: in_ready=0; when slot free, encode u=0, load symbol with out_last=0, go TAIL2.
REQ-026 TAIL2: in_ready=0; when slot free, encode u=0, load symbol with out_last=1, go DATA.
REQ-027 After two tail bits state is 00; next frame starts from state 00.
REQ-028 Single-bit frame (first bit has in_last=1) SHALL produce three symbols, last flagged.
REQ-029 in_valid while in_ready=0 ignored; no bit lost or duplicated.

Reset
REQ-030 rst high at any clock edge, including mid-frame or mid-tail: FSM=DATA, enc_state=00, out_valid=0, out_sym=00, out_last=0, busy=0, pending symbol discarded; in_ready=1 in the cycle after rst deasserts.

Configuration
REQ-031 Macro CONV_ENC_TAIL_EN: defined -> zero-tail termination per REQ-024..REQ-028; undefined -> TAIL1/TAIL2 absent, out_last set on the symbol of the in_last bit, enc_state forced to 00 on that transfer.

Verification
REQ-032 Default G, tail on, bits 1,0,1,1(last), out_ready=1 -> out_sym 11,10,00,01,01,11 on consecutive cycles, out_last only on 6th, enc_state ends 00.
REQ-033 Same frame, CONV_ENC_TAIL_EN undefined -> 11,10,00,01, out_last on 4th, enc_state 00 afterwards.
REQ-034 out_ready=0 for 3 cycles after first symbol 11 -> out_sym stays 11, in_ready=0, no extra transfer; stream resumes unchanged.
REQ-035 Single bit 1 with in_last, tail on -> 11,10,11, out_last on 3rd, in_ready=0 for two tail cycles.
REQ-036 rst pulsed after 2nd symbol of REQ-032 frame -> out_valid=0, enc_state=00 next cycle; new frame 1(last) yields 11,10,11.
REQ-037 8 random bits, in_valid and out_ready held high -> 8 data symbols in 8 consecutive cycles matching a reference model.

Source files
------------

// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3 -- rate 1/2, constraint length 3 convolutional encoder.
//
// Accepts one information bit per cycle through a valid/ready input. It emits
// one 2-bit coded symbol {g0,g1} per accepted bit through a valid/ready
// output backed by a single output register.
//
// Optional feature macro CONV_ENC_TAIL_EN:
//   defined   - zero-tail termination. After the in_last bit, two u=0 tail
//               symbols are appended. The second tail symbol carries out_last.
//   undefined - no tail. out_last rides on the symbol of the in_last bit, and
//               the trellis state is cleared on that transfer.
//
// Parameters
//   G0, G1     generator polynomials over taps {u,d1,d2} for symbol bits 1/0
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   source presents in_bit/in_last
//   in_ready   encoder accepts a data bit this cycle
//   in_bit     information bit u
//   in_last    final data bit of a frame
//   out_valid  out_sym/out_last valid
//   out_ready  sink accepts the symbol this cycle
//   out_sym    coded symbol {g0,g1}
//   out_last   final symbol of a frame
//   enc_state  trellis state {d1,d2}
//   busy       frame in flight (first accepted bit .. last symbol consumed)
module conv_encoder_k3 #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic [1:0] enc_state,
  output logic       busy
);

  typedef enum logic [1:0] {DATA, TAIL1, TAIL2} fsm_t;

  fsm_t       state_q, state_d;
  logic       slot_free;
  logic       in_xfer;
  logic       load;
  logic       u;
  logic       sym_last;
  logic [1:0] nxt_enc;
  logic       consume_last;

  function automatic logic [1:0] encode(input logic bit_u, input logic [1:0] st);
    logic [2:0] taps;
    taps = {bit_u, st};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // The output register can take a new symbol when it is empty or being drained.
  assign slot_free    = !out_valid || out_ready;
  assign in_ready     = (state_q == DATA) && slot_free;
  assign in_xfer      = in_valid && in_ready;
  assign consume_last = out_valid && out_ready && out_last;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    u        = 1'b0;
    sym_last = 1'b0;
    nxt_enc  = {1'b0, enc_state[1]};  // shift in a zero (tail bit)
    case (state_q)
      DATA: begin
        if (in_xfer) begin
          load    = 1'b1;
          u       = in_bit;
          nxt_enc = {in_bit, enc_state[1]};
`ifdef CONV_ENC_TAIL_EN
          if (in_last) state_d = TAIL1;
`else
          // Without a tail, the next frame must still start from state 00.
          sym_last = in_last;
          if (in_last) nxt_enc = 2'b00;
`endif
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL1: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = TAIL2;
        end
      end
      TAIL2: begin
        if (slot_free) begin
          load     = 1'b1;
          sym_last = 1'b1;
          state_d  = DATA;
        end
      end
`endif
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DATA;
      enc_state <= 2'b00;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      // The symbol and the state only move on a load. A stalled symbol
      // therefore stays put together with its trellis state.
      if (load) begin
        out_valid <= 1'b1;
        out_sym   <= encode(u, enc_state);
        out_last  <= sym_last;
        enc_state <= nxt_enc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // The next frame's first bit may land on the same cycle as the previous
      // frame's last symbol. Acceptance wins in that case.
      if (in_xfer)           busy <= 1'b1;
      else if (consume_last) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3.
//
// The main process queues stimulus bits and their hand-computed expected
// symbols. A driver process feeds the bits. A monitor pops and compares every
// symbol handshake. Expectations follow the build: tail or no tail,
// depending on CONV_ENC_TAIL_EN.
module tb_conv_encoder_k3;

  typedef struct packed { logic b; logic l; } stim_t;
  typedef struct packed { logic [1:0] sym; logic last; } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_bit, in_last;
  logic       out_valid, out_ready, out_last, busy;
  logic [1:0] out_sym, enc_state;

  stim_t in_q[$];
  exp_t  exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_pop  = 0;

  conv_encoder_k3 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_last(out_last), .enc_state(enc_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_sym(input logic [1:0] s, input logic l);
    exp_t e;
    e.sym = s; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic b, input logic l);
    stim_t s;
    s.b = b; s.l = l;
    in_q.push_back(s);
  endtask

  // Driver: updates inputs 2 time units after each rising edge.
  initial begin : drv
    logic fire;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    forever begin
      @(negedge clk);
      fire = in_valid && in_ready && !rst;
      @(posedge clk); #2;
      if (fire && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0) begin
        in_valid = 1'b1; in_bit = in_q[0].b; in_last = in_q[0].l;
      end else begin
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
      end
    end
  end

  // Monitor: a symbol handshake seen at the negedge completes on the next rising edge.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_unexpected: got sym %b last %b with no symbol expected", out_sym, out_last);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sym", {30'd0, out_sym}, {30'd0, e.sym});
          chk("sb_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called at a negedge. Waits, within a bound, for the frame to drain.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0 || busy || out_valid) && n < 60) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= 60) begin
      n_fail++;
      $display("FAIL %s_drain: %0d symbols still expected after %0d cycles", nm, exp_q.size(), n);
      exp_q.delete();
    end
    chk({nm, "_enc_end"}, {30'd0, enc_state}, 32'd0);
  endtask

  // Expected symbols for frame 1,0,1,1(last) with the default generators.
  task automatic expect_frame_1011();
`ifdef CONV_ENC_TAIL_EN
    expect_sym(2'b11, 0); expect_sym(2'b10, 0); expect_sym(2'b00, 0);
    expect_sym(2'b01, 0); expect_sym(2'b01, 0); expect_sym(2'b11, 1);
`else
    expect_sym(2'b11, 0); expect_sym(2'b10, 0); expect_sym(2'b00, 0);
    expect_sym(2'b01, 1);
`endif
  endtask

  initial begin : main
    logic [7:0] rb;
    logic       d1, d2, u;
    int         base, n;
    rst = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_sym", {30'd0, out_sym}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_enc_state", {30'd0, enc_state}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // Basic frame with the sink always ready.
    @(posedge clk); #1;
    expect_frame_1011();
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("f1_busy", {31'd0, busy}, 1);
    wait_idle("f1");

    // Sink stalls for three cycles right after the first symbol.
    @(posedge clk); #1;
    expect_frame_1011();
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_sym", {30'd0, out_sym}, 32'h3);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
      chk("stall_enc", {30'd0, enc_state}, 32'h2);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    wait_idle("stall");

    // Reset after the second symbol is consumed, then a single-bit frame.
    @(posedge clk); #1;
    base = n_pop;
    expect_frame_1011();
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    n = 0;
    while (n_pop < base + 2 && n < 40) begin @(negedge clk); n++; end
    n_chk++;
    if (n >= 40) begin n_fail++; $display("FAIL rst_wait: only %0d symbols seen", n_pop - base); end
    @(posedge clk); #1;
    rst = 1'b1;
    in_q.delete(); exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_enc", {30'd0, enc_state}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
`ifdef CONV_ENC_TAIL_EN
    expect_sym(2'b11, 0); expect_sym(2'b10, 0); expect_sym(2'b11, 1);
`else
    expect_sym(2'b11, 1);
`endif
    send(1, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_valid && in_ready) && n < 20);
`ifdef CONV_ENC_TAIL_EN
    @(negedge clk); chk("tail1_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk); chk("tail2_in_ready", {31'd0, in_ready}, 0);
`else
    @(negedge clk); chk("notail_in_ready", {31'd0, in_ready}, 1);
`endif
    wait_idle("single");

    // Eight random bits at full rate, checked against a reference model.
    rb = 8'($urandom);
    d1 = 1'b0; d2 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      u = rb[i];
`ifdef CONV_ENC_TAIL_EN
      expect_sym({u ^ d1 ^ d2, u ^ d2}, 0);
`else
      expect_sym({u ^ d1 ^ d2, u ^ d2}, i == 7);
`endif
      d2 = d1; d1 = u;
      send(u, i == 7);
    end
`ifdef CONV_ENC_TAIL_EN
    expect_sym({d1 ^ d2, d2}, 0);
    expect_sym({d1, d1}, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rand_in_ready", {31'd0, in_ready}, 1);
      if (i > 0) chk("rand_out_valid", {31'd0, out_valid}, 1);
    end
    wait_idle("rand");

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
